// File: rtl/sram_bus_bridge_pkg.sv
// rtl/sram_bus_bridge_pkg.sv - shared widths and FSM states for the SRAM bus bridge
// Holds the default word-address/data/strobe widths of the 512x32 SRAM and
// the bridge state encoding. Imported by the interface, merge unit and top.
package sram_bridge_pkg;
    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_STRB_W = DEFAULT_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        RMW_WR,
        GAP
    } bridge_state_t;
endpackage

// File: rtl/sram_bus_bridge_if.sv
// rtl/sram_bus_bridge_if.sv - request/response bus between a requester and the SRAM bridge
// Request : req_valid/req_ready handshake carrying req_write, req_addr, req_wdata, req_wstrb.
// Response: rsp_valid/rsp_ready handshake carrying rsp_rdata (0 for writes).
// Modports: master = requester side, slave = bridge side.
interface sram_bus_bridge_if
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();
    localparam int STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_bus_bridge_merge.sv
// rtl/sram_bus_bridge_merge.sv - combinational byte-lane merge for partial writes
// Ports: old_word (current SRAM contents), new_word (request data),
//        strb (lane i selects new_word bits 8i+7:8i), merged (result).
module sram_bridge_merge
    import sram_bridge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] merged
);
    always_comb begin
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/sram_bus_bridge.sv
// rtl/sram_bus_bridge.sv - single-outstanding request bridge onto a 1-cycle-latency SRAM
// Ports: clk, reset_n (synchronous, active-low); bus (slave modport of
//        sram_bus_bridge_if); sram_en/sram_wen/sram_addr/sram_wdata access pulse
//        toward the SRAM wrapper; sram_rdata valid the cycle after a read pulse.
// Build option: SRAM_BRIDGE_RMW_EN enables read-modify-write for partial strobes;
//        without it any nonzero strobe writes the full word.
module sram_bus_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    sram_bus_bridge_if.slave  bus,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    bridge_state_t     state_q, state_d;
    logic              prev_en_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              req_ready;
    logic              accept;
    logic              zero_wr;
    logic              part_wr;
    logic              rsp_set;
    logic [DATA_W-1:0] rsp_set_rdata;

    // Blocking on the previous pulse keeps sram_en from ever firing back to back.
    assign req_ready = reset_n && (state_q == IDLE) &&
                       (!rsp_valid_q || bus.rsp_ready) && !prev_en_q;
    assign accept        = bus.req_valid && req_ready;
    assign zero_wr       = bus.req_write && (bus.req_wstrb == '0);
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef SRAM_BRIDGE_RMW_EN
    localparam int STRB_W = DATA_W / 8;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] merged_q;

    assign part_wr = bus.req_write && !zero_wr && (bus.req_wstrb != '1);

    sram_bridge_merge #(.DATA_W(DATA_W), .STRB_W(STRB_W)) u_merge (
        .old_word (sram_rdata),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

    // Request fields are captured at acceptance so the requester may move on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            merged_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wstrb_q <= bus.req_wstrb;
            end
            if (state_q == RMW_WAIT) begin
                merged_q <= merged;
            end
        end
    end
`else
    assign part_wr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sram_en       = 1'b0;
        sram_wen      = 1'b0;
        sram_addr     = bus.req_addr;
        sram_wdata    = bus.req_wdata;
        rsp_set       = 1'b0;
        rsp_set_rdata = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_write) begin
                        sram_en = 1'b1;
                        state_d = RD_WAIT;
                    end else if (zero_wr) begin
                        rsp_set = 1'b1;
                    end else if (part_wr) begin
                        sram_en = 1'b1;
                        state_d = RMW_WAIT;
                    end else begin
                        sram_en  = 1'b1;
                        sram_wen = 1'b1;
                        rsp_set  = 1'b1;
                        state_d  = GAP;
                    end
                end
            end
            RD_WAIT: begin
                rsp_set       = 1'b1;
                rsp_set_rdata = sram_rdata;
                state_d       = IDLE;
            end
`ifdef SRAM_BRIDGE_RMW_EN
            RMW_WAIT: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                sram_en    = 1'b1;
                sram_wen   = 1'b1;
                sram_addr  = addr_q;
                sram_wdata = merged_q;
                rsp_set    = 1'b1;
                state_d    = IDLE;
            end
`endif
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!reset_n) begin
            sram_en  = 1'b0;
            sram_wen = 1'b0;
        end
    end

    // A new response loaded in the retiring cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_en_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            prev_en_q <= sram_en;
            if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (rsp_set) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_set_rdata;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb/tb_sram_bus_bridge.sv - self-checking bench for sram_bus_bridge with SRAM model and reference memory
module tb_sram_bus_bridge;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sram_en, sram_wen;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_bus_bridge_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    sram_bus_bridge #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [512] = '{default: '0};
    logic [31:0] ref_mem [512] = '{default: '0};
    int   total = 0, bad = 0;
    int   cyc = 0, en_cnt = 0, wr_cnt = 0, consec = 0;
    logic last_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_rdata     <= mem[sram_addr];
        end
    end

    always @(negedge clk) begin
        en_cnt  <= en_cnt + int'(sram_en);
        wr_cnt  <= wr_cnt + int'(sram_en && sram_wen);
        consec  <= consec + int'(sram_en && last_en);
        last_en <= sram_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [3:0] s);
        logic [31:0] m;
`ifdef SRAM_BRIDGE_RMW_EN
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
        m = (s != 4'h0) ? 32'hFFFF_FFFF : 32'h0;
`endif
        return (old & ~m) | (nw & m);
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic txn(input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int hold, input string tag);
        logic [31:0] exp_rd;
        int exp_l, exp_p, t, n, e0, eh, lat;
        exp_rd = w ? 32'h0 : ref_mem[a];
        if (!w) begin exp_l = 2; exp_p = 1; end
        else if (s == 4'h0) begin exp_l = 1; exp_p = 0; end
`ifdef SRAM_BRIDGE_RMW_EN
        else if (s != 4'hF) begin exp_l = 3; exp_p = 2; end
`endif
        else begin exp_l = 1; exp_p = 1; end
        if (w) ref_mem[a] = apply_write(ref_mem[a], d, s);
        e0 = en_cnt;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
        bus.req_wdata = d;    bus.req_wstrb = s; bus.rsp_ready = 1'b0;
        #1;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin @(posedge clk); #2; t++; end
        chk({tag, "_accept"}, 32'(t < 20), 32'd1);
        n = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;         bus.req_write = 1'($urandom);
        bus.req_addr  = 9'($urandom); bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
        #1;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 20) begin @(posedge clk); #2; t++; end
        lat = cyc - n;
        chk({tag, "_lat"}, lat, exp_l);
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        if (hold > 0) begin
            eh = en_cnt;
            bus.req_valid = 1'b1; bus.req_write = 1'b0;
            repeat (hold) begin
                @(posedge clk); #2;
                chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
                chk({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
                chk({tag, "_hold_ready"}, bus.req_ready, 0);
            end
            chk({tag, "_hold_no_en"}, en_cnt - eh, 0);
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_pulses"}, en_cnt - e0, exp_p);
    endtask

    task automatic midflight_reset(input logic w, input logic [8:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input string tag);
        int w0;
        w0 = wr_cnt;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
        bus.req_wdata = d;    bus.req_wstrb = s; bus.rsp_ready = 1'b0;
        #1;
        chk({tag, "_acc"}, bus.req_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, bus.req_ready, 0);
        chk({tag, "_rst_en"}, sram_en, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; bus.req_valid = 1'b0;
        repeat (3) begin
            #1;
            chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
            chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
            chk({tag, "_en"}, sram_en, 0);
            @(posedge clk); #1;
        end
        chk({tag, "_wr"}, wr_cnt - w0, 0);
        chk({tag, "_mem"}, mem[a], ref_mem[a]);
    endtask

    initial begin
        logic [8:0]  ba;
        logic [31:0] bd;
        logic [3:0]  rs;
        int acc, e0, k, diffs;
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0;   bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        chk("reset_sram_en",   sram_en, 0);
        chk("reset_sram_wen",  sram_wen, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b1, 9'h005, 32'hDEAD_BEEF, 4'hF, 0, "wr005");
        txn(1'b0, 9'h005, 32'h0,         4'h0, 0, "rd005");
        txn(1'b0, 9'h005, 32'h0,         4'h0, 5, "rdhold");
        txn(1'b1, 9'h005, 32'h1234_5678, 4'h0, 0, "zstrb");
        txn(1'b0, 9'h005, 32'h0,         4'h0, 0, "zstrb_rd");
        txn(1'b1, 9'h1FF, 32'h1122_3344, 4'hF, 0, "pre1ff");
        txn(1'b1, 9'h1FF, 32'hAABB_CCDD, 4'h5, 0, "part1ff");
        txn(1'b0, 9'h1FF, 32'h0,         4'h0, 0, "rd1ff");

        // Back-to-back full writes with the requester never idle.
        acc = 0; e0 = en_cnt;
        bus.rsp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_wstrb = 4'hF;
        ba = 9'($urandom_range(0, 7)); bd = $urandom;
        for (int c = 0; c < 20; c++) begin
            bus.req_addr = ba; bus.req_wdata = bd;
            #1;
            if (bus.req_ready === 1'b1) begin
                acc++;
                ref_mem[ba] = bd;
                ba = 9'($urandom_range(0, 7)); bd = $urandom;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.rsp_ready = 1'b0;
        chk("burst_accepts", acc, 10);
        chk("burst_pulses", en_cnt - e0, 10);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            rs = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'($urandom_range(1, 14));
            ba = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
            txn(1'($urandom_range(0, 1)), ba, $urandom, rs, int'($urandom_range(0, 1)), "rand");
        end

        midflight_reset(1'b0, 9'h005, 32'h0, 4'h0, "rst_rd");
`ifdef SRAM_BRIDGE_RMW_EN
        txn(1'b1, 9'h010, 32'h0102_0304, 4'hF, 0, "pre010");
        midflight_reset(1'b1, 9'h010, 32'hFFFF_FFFF, 4'h3, "rst_rmw");
        txn(1'b0, 9'h010, 32'h0, 4'h0, 0, "rd010");
`endif

        chk("no_back_to_back_en", consec, 0);
        diffs = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        chk("mem_image", diffs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
